// File: rtl/mem_access_controller.sv
// SRAM access sequencer: turns memory-stage read/write commands into
// async SRAM strobe sequences with configurable wait states.
module mem_access_controller #(
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1,
  parameter logic [15:0] IDLE_ADDR  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  memControl,
  input  logic [15:0] memAddr,
  input  logic [15:0] memDataIn,
  output logic [15:0] memDataOut,
  output logic        busy,
  output logic        done,
  output logic [15:0] ramAddr,
  output logic [15:0] ramDataOut,
  output logic        ramDataOe,
  input  logic [15:0] ramDataIn,
  output logic        ramCe_n,
  output logic        ramOe_n,
  output logic        ramWe_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, done_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_dout_q, ram_dout_d;
  logic        ram_doe_q, ram_doe_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (memControl == 2'b10) begin
          addr_d  = memAddr;
          cnt_d   = RD_LOAD;
          state_d = S_RD;
        end else if (memControl == 2'b01) begin
          addr_d  = memAddr;
          wdata_d = memDataIn;
          state_d = S_WR_SETUP;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          dout_d  = ramDataIn;
          state_d = S_DONE;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin is a flop.
  always_comb begin
    ce_d       = 1'b1;
    oe_d       = 1'b1;
    we_d       = 1'b1;
    ram_doe_d  = 1'b0;
    ram_addr_d = IDLE_ADDR;
    ram_dout_d = ram_dout_q;
    done_d     = 1'b0;
    unique case (state_d)
      S_RD: begin
        ce_d       = 1'b0;
        oe_d       = 1'b0;
        ram_addr_d = addr_d;
      end
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        ce_d       = 1'b0;
        we_d       = (state_d != S_WR_PULSE);
        ram_doe_d  = 1'b1;
        ram_addr_d = addr_d;
        ram_dout_d = wdata_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      dout_q     <= 16'h0000;
      done_q     <= 1'b0;
      ram_addr_q <= IDLE_ADDR;
      ram_dout_q <= 16'h0000;
      ram_doe_q  <= 1'b0;
      ce_q       <= 1'b1;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_doe_q  <= ram_doe_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign memDataOut = dout_q;
  assign ramAddr    = ram_addr_q;
  assign ramDataOut = ram_dout_q;
  assign ramDataOe  = ram_doe_q;
  assign ramCe_n    = ce_q;
  assign ramOe_n    = oe_q;
  assign ramWe_n    = we_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: async SRAM model plus a
// transaction-level reference of latency, strobe counts and data.
module tb_mem_access_controller;

  localparam int RW = 1;
  localparam int WW = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  memControl;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut;
  logic        busy;
  logic        done;
  logic [15:0] ramAddr;
  logic [15:0] ramDataOut;
  logic        ramDataOe;
  logic [15:0] ramDataIn;
  logic        ramCe_n;
  logic        ramOe_n;
  logic        ramWe_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sram [0:65535];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_dout;

  mem_access_controller #(
    .READ_WAIT (RW),
    .WRITE_WAIT(WW),
    .IDLE_ADDR (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memControl(memControl),
    .memAddr   (memAddr),
    .memDataIn (memDataIn),
    .memDataOut(memDataOut),
    .busy      (busy),
    .done      (done),
    .ramAddr   (ramAddr),
    .ramDataOut(ramDataOut),
    .ramDataOe (ramDataOe),
    .ramDataIn (ramDataIn),
    .ramCe_n   (ramCe_n),
    .ramOe_n   (ramOe_n),
    .ramWe_n   (ramWe_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_pat(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  // Async SRAM: reads while CE/OE low, writes on WE rising edge.
  assign ramDataIn = (!ramCe_n && !ramOe_n) ? sram[ramAddr] : 16'hDEAD;

  always @(posedge ramWe_n)
    if (ramCe_n === 1'b0 && ramDataOe === 1'b1)
      sram[ramAddr] = ramDataOut;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_cmp++;
      if (ramDataOe === 1'b1 && ramOe_n === 1'b0) begin
        n_bad++;
        $display("FAIL contention: ramDataOe=1 with ramOe_n=0 at %0t", $time);
      end
    end
  end

  task automatic do_access(input logic [1:0] cmd, input logic [15:0] addr,
                           input logic [15:0] data, input bit scramble,
                           input string tag);
    bit          is_rd;
    int          done_k, busy_n, we_n, rd_n, oe_w, doe_n, exp_lat;
    bit          bad_addr, bad_data;
    logic [15:0] exp, dout_at_done;
    is_rd = (cmd == 2'b10);
    exp = is_rd ? ref_rd(addr) : exp_dout;
    exp_lat = is_rd ? RW + 1 : WW + 3;
    done_k = 0; busy_n = 0; we_n = 0; rd_n = 0; oe_w = 0; doe_n = 0;
    bad_addr = 0; bad_data = 0; dout_at_done = 16'hxxxx;
    @(negedge clk);
    memControl = cmd; memAddr = addr; memDataIn = data;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (ramWe_n === 1'b0) we_n++;
      if (ramCe_n === 1'b0 && ramOe_n === 1'b0) rd_n++;
      if (ramOe_n === 1'b0 && !is_rd) oe_w++;
      if (ramDataOe === 1'b1) begin
        doe_n++;
        if (ramDataOut !== data) bad_data = 1;
      end
      if (ramCe_n === 1'b0 && ramAddr !== addr) bad_addr = 1;
      if (done === 1'b1) begin
        done_k = k;
        dout_at_done = memDataOut;
        memControl = 2'b00;
      end else if (scramble) begin
        memAddr = 16'($urandom);
        memDataIn = 16'($urandom);
      end
    end
    n_cmp++;
    if (done_k != exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, done_k, exp_lat);
    end
    n_cmp++;
    if (busy_n != exp_lat) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, exp_lat);
    end
    n_cmp++;
    if (we_n != (is_rd ? 0 : WW)) begin
      n_bad++;
      $display("FAIL %s we_cycles: got %0d want %0d", tag, we_n, is_rd ? 0 : WW);
    end
    n_cmp++;
    if (rd_n != (is_rd ? RW : 0)) begin
      n_bad++;
      $display("FAIL %s rd_cycles: got %0d want %0d", tag, rd_n, is_rd ? RW : 0);
    end
    n_cmp++;
    if (doe_n != (is_rd ? 0 : WW + 2)) begin
      n_bad++;
      $display("FAIL %s doe_cycles: got %0d want %0d", tag, doe_n,
               is_rd ? 0 : WW + 2);
    end
    n_cmp++;
    if (oe_w != 0 || bad_addr || bad_data) begin
      n_bad++;
      $display("FAIL %s bus: oe_in_write=%0d bad_addr=%0d bad_data=%0d want 0/0/0",
               tag, oe_w, bad_addr, bad_data);
    end
    n_cmp++;
    if (dout_at_done !== exp) begin
      n_bad++;
      $display("FAIL %s memDataOut: got %h want %h", tag, dout_at_done, exp);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || ramAddr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL %s after_done: busy=%b done=%b addr=%h want 0 0 ffff",
               tag, busy, done, ramAddr);
    end
    if (is_rd) begin
      exp_dout = exp;
    end else begin
      ref_mem[addr] = data;
      n_cmp++;
      if (sram[addr] !== data) begin
        n_bad++;
        $display("FAIL %s sram[%h]: got %h want %h", tag, addr, sram[addr], data);
      end
    end
  endtask

  task automatic check_idle_pins(input string tag, input logic [15:0] dout);
    n_cmp++;
    if (ramCe_n !== 1'b1 || ramOe_n !== 1'b1 || ramWe_n !== 1'b1 ||
        ramDataOe !== 1'b0 || ramAddr !== 16'hFFFF || memDataOut !== dout ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ce=%b oe=%b we=%b doe=%b addr=%h dout=%h busy=%b done=%b want 1 1 1 0 ffff %h 0 0",
               tag, ramCe_n, ramOe_n, ramWe_n, ramDataOe, ramAddr,
               memDataOut, busy, done, dout);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_pins("reset_poweron", 16'h0000);
    rst = 1'b0;
    exp_dout = 16'h0000;
    @(negedge clk);
    memControl = 2'b10; memAddr = 16'h0042;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ramCe_n !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_read_start: busy=%b ce=%b want 1 0", busy, ramCe_n);
    end
    rst = 1'b1; memControl = 2'b00;
    @(negedge clk);
    check_idle_pins("reset_midread_1", 16'h0000);
    @(negedge clk);
    check_idle_pins("reset_midread_2", 16'h0000);
    rst = 1'b0;
    exp_dout = 16'h0000;
  endtask

  task automatic test_read();
    sram[16'h1234] = 16'hBEEF;
    ref_mem[16'h1234] = 16'hBEEF;
    do_access(2'b10, 16'h1234, 16'h0000, 1'b0, "read_1234");
  endtask

  task automatic test_write();
    do_access(2'b01, 16'h8000, 16'h5A5A, 1'b0, "write_8000");
  endtask

  task automatic test_reserved();
    bit bad;
    @(negedge clk);
    memControl = 2'b11; memAddr = 16'h0101; memDataIn = 16'h9999;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ramCe_n !== 1'b1 || ramOe_n !== 1'b1 || ramWe_n !== 1'b1 ||
          ramDataOe !== 1'b0 || busy !== 1'b0 || memDataOut !== exp_dout)
        bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL reserved_cmd: activity seen, dout=%h want %h busy=%b want 0",
               memDataOut, exp_dout, busy);
    end
    memControl = 2'b00;
  endtask

  task automatic test_back_to_back();
    int d1, d2, idle_between, ndone;
    logic [15:0] dout2;
    d1 = 0; d2 = 0; idle_between = 0; ndone = 0; dout2 = 16'hxxxx;
    @(negedge clk);
    memControl = 2'b01; memAddr = 16'h0010; memDataIn = 16'h00AA;
    for (int k = 1; k <= 30 && d2 == 0; k++) begin
      @(negedge clk);
      if (d1 != 0 && busy === 1'b0) idle_between++;
      if (done === 1'b1) begin
        ndone++;
        if (d1 == 0) begin
          d1 = k;
          memControl = 2'b10; memAddr = 16'h0010;
        end else begin
          d2 = k;
          dout2 = memDataOut;
          memControl = 2'b00;
        end
      end else if (busy === 1'b1 && !(d1 != 0 && k == d1 + 1)) begin
        memAddr = 16'($urandom) | 16'h4000;
        memDataIn = 16'($urandom);
      end
    end
    n_cmp++;
    if (ndone != 2 || d1 != WW + 3 || d2 != d1 + RW + 2) begin
      n_bad++;
      $display("FAIL b2b_timing: done at %0d,%0d (n=%0d) want %0d,%0d",
               d1, d2, ndone, WW + 3, WW + 3 + RW + 2);
    end
    n_cmp++;
    if (idle_between != 1) begin
      n_bad++;
      $display("FAIL b2b_idle: got %0d idle cycles want 1", idle_between);
    end
    n_cmp++;
    if (dout2 !== 16'h00AA) begin
      n_bad++;
      $display("FAIL b2b_readback: got %h want 00aa", dout2);
    end
    ref_mem[16'h0010] = 16'h00AA;
    exp_dout = 16'h00AA;
    @(negedge clk);
  endtask

  task automatic test_reset_wr_pulse();
    bit seen_done;
    @(negedge clk);
    memControl = 2'b01; memAddr = 16'h7777; memDataIn = 16'h1357;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ramWe_n !== 1'b0 || ramDataOe !== 1'b1) begin
      n_bad++;
      $display("FAIL wrpulse_entry: we=%b doe=%b want 0 1", ramWe_n, ramDataOe);
    end
    rst = 1'b1; memControl = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (ramWe_n !== 1'b1 || ramDataOe !== 1'b0 || ramCe_n !== 1'b1 ||
        done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wrpulse_abort: we=%b doe=%b ce=%b done=%b busy=%b want 1 0 1 0 0",
               ramWe_n, ramDataOe, ramCe_n, done, busy);
    end
    rst = 1'b0;
    exp_dout = 16'h0000;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    n_cmp++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL wrpulse_no_done: got done=1 want 0");
    end
    do_access(2'b10, 16'h1234, 16'h0000, 1'b0, "read_after_abort");
  endtask

  task automatic test_random();
    logic [1:0]  cmd;
    logic [15:0] a, d;
    bit          scr;
    for (int i = 0; i < 40; i++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      a = 16'h0100 | 16'($urandom_range(0, 15));
      d = 16'($urandom);
      scr = 1'($urandom_range(0, 1));
      do_access(cmd, a, d, scr, cmd == 2'b10 ? "rand_read" : "rand_write");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    memControl = 2'b00;
    memAddr = 16'h0000;
    memDataIn = 16'h0000;
    exp_dout = 16'h0000;
    for (int i = 0; i < 65536; i++) sram[i] = init_pat(16'(i));
    test_reset();
    test_read();
    test_write();
    test_reserved();
    test_back_to_back();
    test_reset_wr_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Responder side of the CPU memory request interface. Takes the 2-bit memory command (01 = write, 10 = read, 00 = idle) and the 16-bit address from the memory stage, and runs the access against an asynchronous external SRAM.
- Sequences the SRAM strobes, returns read data, and reports busy/done so the pipeline can stall.
- Sits between the memory stage and the board SRAM pins.

Parameters:
- READ_WAIT, 1: cycles the SRAM is held in read (CE/OE low) before data is captured; legal range 1..15.
- WRITE_WAIT, 1: cycles WE is held low; legal range 1..15.
- IDLE_ADDR, 16'hFFFF: value driven on ramAddr when no access is in progress.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- memControl  in  2  command: 00 idle, 01 write, 10 read, 11 reserved (treated as idle).
- memAddr  in  16  access address.
- memDataIn  in  16  write data.
- memDataOut  out  16  read data; holds the last read value.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when an access completes.
- ramAddr  out  16  SRAM address.
- ramDataOut  out  16  data driven toward the SRAM.
- ramDataOe  out  1  high = drive ramDataOut onto the SRAM bus.
- ramDataIn  in  16  SRAM bus value.
- ramCe_n, ramOe_n, ramWe_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - ramCe_n, ramOe_n, ramWe_n = 1; ramDataOe = 0.
  - ramAddr = IDLE_ADDR; ramDataOut = 0; memDataOut = 0; done = 0.
  - Reset mid-access aborts immediately: WE/OE/CE deassert and the bus is released on the same edge. No done pulse is issued.
- All outputs are registered except busy, which is decoded from the state register.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit wait counter is loaded on entry to RD/WR_PULSE and decremented each cycle.
- IDLE:
  - memControl sampled every edge.
  - 10 latches memAddr and goes to RD.
  - 01 latches memAddr and memDataIn, then goes to WR_SETUP.
  - 00 and 11 stay in IDLE.
- RD:
  - ramAddr = latched address; ramCe_n = 0, ramOe_n = 0, ramDataOe = 0.
  - Lasts exactly READ_WAIT cycles.
  - On the edge ending the last RD cycle, ramDataIn is captured into memDataOut and the FSM goes to DONE.
- WR_SETUP (1 cycle): ramCe_n = 0, ramWe_n = 1, ramDataOe = 1, ramDataOut = latched data, address stable.
- WR_PULSE: as WR_SETUP but with ramWe_n = 0; lasts exactly WRITE_WAIT cycles.
- WR_HOLD (1 cycle): ramWe_n = 1; CE, address, data and ramDataOe are still held, so data is stable after the WE rising edge.
- ramOe_n stays 1 throughout every write state.
- DONE (1 cycle):
  - done = 1; strobes deasserted; ramDataOe = 0; ramAddr = IDLE_ADDR.
  - Inputs are ignored; next state is IDLE.
- Latency, for a request present before edge N:
  - Read: RD during cycles N+1..N+READ_WAIT; done and valid memDataOut in cycle N+READ_WAIT+1.
  - Write: done in cycle N+WRITE_WAIT+3.
- Handshake:
  - The requester holds memControl, memAddr and memDataIn stable while busy is high.
  - The requester must drive memControl = 00 by the edge following the done cycle.
  - A command still present in IDLE is a new access (back-to-back accesses are legal, with one IDLE cycle minimum between them).
- Address and data inputs changing after acceptance have no effect; the latched copies are used.
- memDataOut is unchanged by writes and by 00/11 commands.
- Bus contention rule: ramDataOe and ramOe_n = 0 are never true in the same cycle.

Test Plan:
- Reset: assert rst for 2 cycles during an active read -> all strobes 1, ramDataOe 0, ramAddr FFFF, memDataOut 0000, busy 0, done 0 on the next edge.
- Read, READ_WAIT=1: memControl=10, memAddr=1234, SRAM model returns BEEF -> CE/OE low for 1 cycle with ramAddr=1234; done in cycle N+2; memDataOut=BEEF; busy high N+1..N+2.
- Write, WRITE_WAIT=2: memControl=01, memAddr=8000, memDataIn=5A5A -> WE low exactly 2 cycles; ramDataOut=5A5A with ramDataOe high from WR_SETUP through WR_HOLD; OE stays high; done in cycle N+5; model location 8000 = 5A5A.
- Reserved/idle: memControl=11 for 5 cycles -> no strobe activity, busy 0, memDataOut unchanged.
- Back-to-back: write 0010 <= 00AA, then immediately read 0010 -> read returns 00AA; exactly one IDLE cycle between the two done pulses; memAddr changes during busy are ignored.
- Reset during WR_PULSE -> ramWe_n returns to 1 and ramDataOe to 0 on the same edge; no done pulse; the next read command completes normally.
